hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL expose these ports: clk  in  1  rising-edge clock.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  decode holds an instruction.
REQ-004 id_rs1, id_rs2, id_rd  in  4 each  source and destination register numbers.
REQ-005 id_regwrite, id_pcwrite, id_is_load  in  1 each  decoded controls.
REQ-006 id_aluin1  in  2  nominal ALU input-1 select: 0 pc, 1 a, 2 forwarded_aluout, 3 zero.
REQ-007 id_aluin2  in  2  nominal ALU input-2 select: 0 b, 1 constant 2, 2 imm, 3 forwarded_aluout.
REQ-008 ex_branch_taken  in  1  execute stage's registered pcwrite (branch/jump resolved).
REQ-009 aluin1, aluin2  out  2 each  final selects to the execute stage.
REQ-010 regwrite, pcwrite  out  1 each  gated controls to the execute stage.
REQ-011 stall  out  1  hold PC and IF/ID.
REQ-012 flush  out  1  squash the instruction in decode.
REQ-013 stall_count, flush_count  out  16 each  present only under the configuration macro.

Function
REQ-014 State SHALL consist of ex_valid, ex_rd[3:0], ex_regwrite, ex_is_load and flush_cnt[1:0], describing the instruction currently in execute.
REQ-015 issue SHALL be defined as id_valid & !stall & !flush; on each clock edge the ex_* registers load the id_* fields when issue is 1, else ex_valid <= 0 (bubble).
REQ-016 hit1 SHALL be ex_valid & ex_regwrite & (ex_rd != 0) & (ex_rd == id_rs1); hit2 SHALL be the same test against id_rs2.
REQ-017 stall SHALL be combinational: id_valid & ex_is_load & ((hit1 & id_aluin1==1) | (hit2 & id_aluin2==0)) & !flush.
REQ-018 aluin1 SHALL be 2 when hit1 & id_aluin1==1 & !ex_is_load, else id_aluin1.
REQ-019 aluin2 SHALL be 3 when hit2 & id_aluin2==0 & !ex_is_load, else id_aluin2.
REQ-020 Register 0 SHALL never trigger forwarding or stall.
REQ-021 regwrite and pcwrite SHALL equal the id_ values when issue=1, else 0.
REQ-022 When ex_branch_taken=1 at a clock edge, flush_cnt SHALL load 2, including when flush_cnt is already nonzero.
REQ-023 Otherwise flush_cnt SHALL decrement when nonzero and hold at 0.
REQ-024 flush SHALL equal (flush_cnt != 0).
REQ-025 When flush and a stall condition coincide, flush SHALL win: stall=0 and the slot is squashed.
REQ-026 A stall SHALL last exactly one cycle, because the inserted bubble clears ex_valid.
REQ-027 Forwarding latency SHALL be zero cycles: selects are valid in the same cycle as the id_ inputs.

Reset
REQ-028 While rst=0, all state SHALL clear asynchronously: ex_valid=0, ex_rd=0, ex_regwrite=0, ex_is_load=0, flush_cnt=0, counters=0.
REQ-029 Consequently during reset stall=0, flush=0, aluin1=id_aluin1, aluin2=id_aluin2, and regwrite/pcwrite follow the id_ inputs gated by id_valid.
REQ-030 On reset deassertion mid-flush, the flush SHALL be abandoned (flush_cnt is 0) and no stale forwarding SHALL occur.

Configuration
REQ-031 With macro HAZARD_STATS_EN defined, stall_count SHALL increment on each cycle with stall=1, and flush_count on each cycle with flush=1.
REQ-032 Both counters SHALL saturate at 16'hFFFF.
REQ-033 Without HAZARD_STATS_EN, the stall_count and flush_count ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Forward rs1: issue rd=3 regwrite=1 (ALU op), then id_rs1=3 with id_aluin1=1 -> aluin1=2, stall=0.
REQ-035 Forward rs2 with imm: prior rd=5; next id_rs2=5 with id_aluin2=2 -> aluin2=2 (no forward); with id_aluin2=0 -> aluin2=3.
REQ-036 Load-use: issue load rd=4, then id_rs1=4 with id_aluin1=1 -> stall=1 for exactly 1 cycle, regwrite=0; the next cycle has stall=0 and aluin1=1.
REQ-037 Branch: pulse ex_branch_taken -> flush=1 for 2 cycles, regwrite=pcwrite=0; a second pulse during cycle 1 of the flush extends it to 2 further cycles.
REQ-038 Zero register: prior rd=0 regwrite=1, next id_rs1=0 -> aluin1 unchanged, stall=0.
REQ-039 Reset: assert rst=0 with flush_cnt=2 and ex_is_load=1 -> flush=0 and stall=0 immediately; under HAZARD_STATS_EN, 70000 stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Decode-stage hazard unit for a two-deep (decode -> execute)
//            pipeline. Tracks the instruction in execute, forwards the ALU
//            result into the decode-stage ALU selects, stalls on load-use,
//            and squashes two decode slots after a taken branch/jump.
// Config   : define HAZARD_STATS_EN to add saturating stall/flush counters.
// Ports    :
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   id_valid        decode holds an instruction
//   id_rs1/rs2/rd   source/destination register numbers (4 b)
//   id_regwrite     decoded register write enable
//   id_pcwrite      decoded PC write enable
//   id_is_load      decoded instruction is a load
//   id_aluin1       nominal ALU-1 select (0 pc, 1 a, 2 fwd, 3 zero)
//   id_aluin2       nominal ALU-2 select (0 b, 1 two, 2 imm, 3 fwd)
//   ex_branch_taken execute stage resolved a taken branch/jump
//   aluin1/aluin2   final ALU selects to execute
//   regwrite        gated register write enable to execute
//   pcwrite         gated PC write enable to execute
//   stall           hold PC and IF/ID
//   flush           squash the instruction in decode
//   stall_count     saturating stall-cycle counter (HAZARD_STATS_EN only)
//   flush_count     saturating flush-cycle counter (HAZARD_STATS_EN only)
// Revision : 1.0  initial release
// ============================================================================
module hazard_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic [3:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_pcwrite,
    input  logic        id_is_load,
    input  logic [1:0]  id_aluin1,
    input  logic [1:0]  id_aluin2,
    input  logic        ex_branch_taken,
    output logic [1:0]  aluin1,
    output logic [1:0]  aluin2,
    output logic        regwrite,
    output logic        pcwrite,
    output logic        stall,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
`endif
    output logic        flush
);

    localparam logic [1:0] SEL1_A    = 2'd1;
    localparam logic [1:0] SEL1_FWD  = 2'd2;
    localparam logic [1:0] SEL2_B    = 2'd0;
    localparam logic [1:0] SEL2_FWD  = 2'd3;
    localparam logic [1:0] FLUSH_LEN = 2'd2;

    // Instruction currently in execute
    logic       ex_valid;
    logic [3:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_is_load;
    logic [1:0] flush_cnt;

    logic hit1;
    logic hit2;
    logic use1;
    logic use2;
    logic issue;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign hit1  = ex_valid & ex_regwrite & (ex_rd != 4'd0) & (ex_rd == id_rs1);
    assign hit2  = ex_valid & ex_regwrite & (ex_rd != 4'd0) & (ex_rd == id_rs2);
    assign use1  = hit1 & (id_aluin1 == SEL1_A);
    assign use2  = hit2 & (id_aluin2 == SEL2_B);

    assign flush = (flush_cnt != 2'd0);
    // A load result is not available until after execute, so a dependent
    // instruction must wait one slot. A pending flush squashes it anyway.
    assign stall = id_valid & ex_is_load & (use1 | use2) & ~flush;
    assign issue = id_valid & ~stall & ~flush;

    assign aluin1   = (use1 & ~ex_is_load) ? SEL1_FWD : id_aluin1;
    assign aluin2   = (use2 & ~ex_is_load) ? SEL2_FWD : id_aluin2;
    assign regwrite = issue & id_regwrite;
    assign pcwrite  = issue & id_pcwrite;

    // Execute-stage tracking; a non-issue slot becomes a bubble, which is
    // also what limits a load-use stall to a single cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_rd       <= 4'd0;
            ex_regwrite <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (issue) begin
            ex_valid    <= 1'b1;
            ex_rd       <= id_rd;
            ex_regwrite <= id_regwrite;
            ex_is_load  <= id_is_load;
        end else begin
            ex_valid    <= 1'b0;
        end
    end

    // A new taken branch always restarts the two-slot squash window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= 2'd0;
        end else if (ex_branch_taken) begin
            flush_cnt <= FLUSH_LEN;
        end else if (flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Directed self-checking bench for hazard_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_controller;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic [3:0]  id_rd;
    logic        id_regwrite;
    logic        id_pcwrite;
    logic        id_is_load;
    logic [1:0]  id_aluin1;
    logic [1:0]  id_aluin2;
    logic        ex_branch_taken;
    logic [1:0]  aluin1;
    logic [1:0]  aluin2;
    logic        regwrite;
    logic        pcwrite;
    logic        stall;
    logic        flush;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    int tests;
    int fails;

    hazard_controller dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_pcwrite      (id_pcwrite),
        .id_is_load      (id_is_load),
        .id_aluin1       (id_aluin1),
        .id_aluin2       (id_aluin2),
        .ex_branch_taken (ex_branch_taken),
        .aluin1          (aluin1),
        .aluin2          (aluin2),
        .regwrite        (regwrite),
        .pcwrite         (pcwrite),
        .stall           (stall),
`ifdef HAZARD_STATS_EN
        .stall_count     (stall_count),
        .flush_count     (flush_count),
`endif
        .flush           (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive decode inputs just after a falling edge; checks follow #1 later.
    task automatic step(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input logic rw, input logic pw,
                        input logic ld, input logic [1:0] a1, input logic [1:0] a2,
                        input logic br);
        @(negedge clk);
        id_valid        = v;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rd           = rd;
        id_regwrite     = rw;
        id_pcwrite      = pw;
        id_is_load      = ld;
        id_aluin1       = a1;
        id_aluin2       = a2;
        ex_branch_taken = br;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_regwrite = 0; id_pcwrite = 0; id_is_load = 0;
        id_aluin1 = 0; id_aluin2 = 0; ex_branch_taken = 0;

        // Reset: selects pass through, controls gated only by id_valid
        step(1, 4'd3, 4'd3, 4'd3, 1, 1, 1, 2'd1, 2'd2, 1);
        step(1, 4'd3, 4'd3, 4'd3, 1, 1, 1, 2'd1, 2'd2, 1);
        check("rst_stall",    {15'd0, stall},    16'd0);
        check("rst_flush",    {15'd0, flush},    16'd0);
        check("rst_aluin1",   {14'd0, aluin1},   16'd1);
        check("rst_aluin2",   {14'd0, aluin2},   16'd2);
        check("rst_regwrite", {15'd0, regwrite}, 16'd1);
        check("rst_pcwrite",  {15'd0, pcwrite},  16'd1);
        step(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 0);
        rst = 1'b1;
`ifdef HAZARD_STATS_EN
        check("rst_stall_count", stall_count, 16'd0);
        check("rst_flush_count", flush_count, 16'd0);
`endif

        // Forward rs1 from an ALU op
        step(1, 4'd0, 4'd0, 4'd3, 1, 0, 0, 2'd0, 2'd0, 0);
        check("fwd1_issue_rw", {15'd0, regwrite}, 16'd1);
        step(1, 4'd3, 4'd0, 4'd0, 0, 0, 0, 2'd1, 2'd0, 0);
        check("fwd1_aluin1", {14'd0, aluin1}, 16'd2);
        check("fwd1_stall",  {15'd0, stall},  16'd0);
        check("fwd1_aluin2", {14'd0, aluin2}, 16'd0);

        // Forward rs2: imm select untouched, b select forwarded
        step(1, 4'd0, 4'd0, 4'd5, 1, 0, 0, 2'd0, 2'd0, 0);
        step(1, 4'd0, 4'd5, 4'd0, 0, 0, 0, 2'd0, 2'd2, 0);
        check("fwd2_imm", {14'd0, aluin2}, 16'd2);
        id_aluin2 = 2'd0;
        #1;
        check("fwd2_b", {14'd0, aluin2}, 16'd3);

        // Load-use: one-cycle stall, then no forward from the bubble
        step(1, 4'd0, 4'd0, 4'd4, 1, 0, 1, 2'd0, 2'd0, 0);
        step(1, 4'd4, 4'd0, 4'd6, 1, 1, 0, 2'd1, 2'd0, 0);
        check("lu_stall",    {15'd0, stall},    16'd1);
        check("lu_regwrite", {15'd0, regwrite}, 16'd0);
        check("lu_pcwrite",  {15'd0, pcwrite},  16'd0);
        check("lu_aluin1",   {14'd0, aluin1},   16'd1);
        step(1, 4'd4, 4'd0, 4'd6, 1, 1, 0, 2'd1, 2'd0, 0);
        check("lu_stall_end", {15'd0, stall},    16'd0);
        check("lu_aluin1_2",  {14'd0, aluin1},   16'd1);
        check("lu_regwrite2", {15'd0, regwrite}, 16'd1);
`ifdef HAZARD_STATS_EN
        check("lu_stall_count", stall_count, 16'd1);
`endif

        // Zero register never forwards
        step(1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 2'd0, 2'd0, 0);
        step(1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 2'd1, 2'd0, 0);
        check("zero_aluin1", {14'd0, aluin1}, 16'd1);
        check("zero_stall",  {15'd0, stall},  16'd0);
        check("zero_aluin2", {14'd0, aluin2}, 16'd0);

        // Branch: two flush slots
        step(1, 4'd0, 4'd0, 4'd1, 1, 1, 0, 2'd0, 2'd0, 1);
        step(1, 4'd0, 4'd0, 4'd1, 1, 1, 0, 2'd0, 2'd0, 0);
        check("br_flush1",    {15'd0, flush},    16'd1);
        check("br_regwrite",  {15'd0, regwrite}, 16'd0);
        check("br_pcwrite",   {15'd0, pcwrite},  16'd0);
        step(1, 4'd0, 4'd0, 4'd1, 1, 1, 0, 2'd0, 2'd0, 0);
        check("br_flush2",    {15'd0, flush},    16'd1);
        step(1, 4'd0, 4'd0, 4'd1, 1, 1, 0, 2'd0, 2'd0, 0);
        check("br_flush_end", {15'd0, flush},    16'd0);
        check("br_pcwrite_end", {15'd0, pcwrite}, 16'd1);

        // Second pulse during flush cycle 1 extends it by two more slots
        step(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 1);
        step(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 1);
        check("br2_c1", {15'd0, flush}, 16'd1);
        step(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 0);
        check("br2_c2", {15'd0, flush}, 16'd1);
        step(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 0);
        check("br2_c3", {15'd0, flush}, 16'd1);
        step(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 0);
        check("br2_end", {15'd0, flush}, 16'd0);

        // Flush beats a load-use stall
        step(1, 4'd0, 4'd0, 4'd7, 1, 0, 1, 2'd0, 2'd0, 1);
        step(1, 4'd7, 4'd0, 4'd2, 1, 0, 0, 2'd1, 2'd0, 0);
        check("fs_flush",    {15'd0, flush},    16'd1);
        check("fs_stall",    {15'd0, stall},    16'd0);
        check("fs_regwrite", {15'd0, regwrite}, 16'd0);
        step(1, 4'd7, 4'd0, 4'd2, 1, 0, 0, 2'd1, 2'd0, 0);
        step(1, 4'd7, 4'd0, 4'd2, 1, 0, 0, 2'd1, 2'd0, 0);
        check("fs_after_flush", {15'd0, flush}, 16'd0);
        check("fs_after_stall", {15'd0, stall}, 16'd0);
        check("fs_after_alu1",  {14'd0, aluin1}, 16'd1);

        // Reset mid-flush with a load in execute
        step(1, 4'd0, 4'd0, 4'd8, 1, 0, 1, 2'd0, 2'd0, 1);
        step(1, 4'd8, 4'd0, 4'd0, 0, 0, 0, 2'd1, 2'd0, 0);
        check("rmf_flush_pre", {15'd0, flush}, 16'd1);
        rst = 1'b0;
        #1;
        check("rmf_flush", {15'd0, flush}, 16'd0);
        check("rmf_stall", {15'd0, stall}, 16'd0);
        check("rmf_aluin1", {14'd0, aluin1}, 16'd1);
        step(1, 4'd8, 4'd0, 4'd0, 0, 0, 0, 2'd1, 2'd0, 0);
        rst = 1'b1;
        step(1, 4'd8, 4'd0, 4'd0, 0, 0, 0, 2'd1, 2'd0, 0);
        check("rmf_post_flush", {15'd0, flush},  16'd0);
        check("rmf_post_stall", {15'd0, stall},  16'd0);
        check("rmf_post_alu1",  {14'd0, aluin1}, 16'd1);

`ifdef HAZARD_STATS_EN
        // Continuous branches keep flush high long enough to saturate
        step(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 2'd0, 2'd0, 1);
        repeat (65600) @(negedge clk);
        #1;
        check("flush_count_sat", flush_count, 16'hFFFF);
        ex_branch_taken = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
